z16_writeback: RTL and testbench



---
 rtl/z16_pkg.sv | 16 +
 rtl/z16_tag_fifo.sv | 65 ++++++
 rtl/z16_writeback.sv | 114 +++++++++++
 tb/tb_z16_writeback.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/z16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : z16_pkg
// Brief   : Shared Z16 datapath widths and register-file constants.
// Rev     : 1.0
// ============================================================================
package z16_pkg;

    localparam int Z16_DATA_W     = 16;
    localparam int Z16_REG_ADDR_W = 4;
    localparam int Z16_NUM_REGS   = 16;

    localparam logic [Z16_REG_ADDR_W-1:0] Z16_REG_ZERO = 4'h0;

endpackage : z16_pkg
`default_nettype wire

// File: rtl/z16_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : z16_tag_fifo
// Brief   : Synchronous FIFO of destination-register tags for outstanding loads.
// Rev     : 1.0
// ============================================================================
module z16_tag_fifo
    import z16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic [Z16_REG_ADDR_W-1:0] i_tag,
    input  logic                      i_pop,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [Z16_REG_ADDR_W-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [Z16_REG_ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_tag;
    end

endmodule : z16_tag_fifo
`default_nettype wire

// File: rtl/z16_writeback.sv
`default_nettype none
// ============================================================================
// Module  : z16_writeback
// Brief   : Z16 write-back stage; arbitrates ALU results and load responses
//           onto the register-file write port and tracks pending loads.
// Rev     : 1.0
// ============================================================================
module z16_writeback
    import z16_pkg::*;
#(
    parameter int LOAD_DEPTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ex_valid,
    output logic                      o_ex_ready,
    input  logic                      i_ex_is_load,
    input  logic [Z16_REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic [Z16_DATA_W-1:0]     i_ex_data,
    input  logic                      i_ld_valid,
    input  logic [Z16_DATA_W-1:0]     i_ld_data,
    output logic [Z16_REG_ADDR_W-1:0] o_rd_addr,
    output logic                      o_rd_wen,
    output logic [Z16_DATA_W-1:0]     o_rd_data,
    output logic [Z16_NUM_REGS-1:0]   o_busy,
    output logic                      o_err
);

    logic [Z16_REG_ADDR_W-1:0] r_rd_addr;
    logic                      r_rd_wen;
    logic [Z16_DATA_W-1:0]     r_rd_data;
    logic [Z16_NUM_REGS-1:0]   r_busy;
    logic                      r_err;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [Z16_REG_ADDR_W-1:0] w_head;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_alu_wr;
    logic                      w_ld_wr;
    logic [Z16_NUM_REGS-1:0]   w_busy_nxt;

    // WAW guard first, then structural hazards. Full ignores a same-cycle pop
    // so ready never depends on the response path through the FIFO.
    always_comb begin
        w_ready = 1'b1;
        if (r_busy[i_ex_rd_addr] && (i_ex_rd_addr != Z16_REG_ZERO)) begin
            w_ready = 1'b0;
        end else if (i_ex_is_load) begin
            w_ready = !w_fifo_full;
        end else begin
            w_ready = !i_ld_valid;
        end
    end

    assign w_accept = i_ex_valid && w_ready;
    assign w_push   = w_accept && i_ex_is_load;
    assign w_pop    = i_ld_valid && !w_fifo_empty;
    assign w_alu_wr = w_accept && !i_ex_is_load && (i_ex_rd_addr != Z16_REG_ZERO);
    assign w_ld_wr  = w_pop && (w_head != Z16_REG_ZERO);

    z16_tag_fifo #(
        .DEPTH (LOAD_DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_tag   (i_ex_rd_addr),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // WAW guard keeps the set and clear targets distinct.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ld_wr) w_busy_nxt[w_head] = 1'b0;
        if (w_push && (i_ex_rd_addr != Z16_REG_ZERO)) w_busy_nxt[i_ex_rd_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr <= '0;
            r_rd_wen  <= 1'b0;
            r_rd_data <= '0;
            r_busy    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rd_wen <= w_ld_wr || w_alu_wr;
            r_busy   <= w_busy_nxt;
            if (w_ld_wr) begin
                r_rd_addr <= w_head;
                r_rd_data <= i_ld_data;
            end else if (w_alu_wr) begin
                r_rd_addr <= i_ex_rd_addr;
                r_rd_data <= i_ex_data;
            end
            if (i_ld_valid && w_fifo_empty) r_err <= 1'b1;
        end
    end

    assign o_ex_ready = w_ready;
    assign o_rd_addr  = r_rd_addr;
    assign o_rd_wen   = r_rd_wen;
    assign o_rd_data  = r_rd_data;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule : z16_writeback
`default_nettype wire

// File: tb/tb_z16_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_z16_writeback
// Brief   : Directed self-checking bench for z16_writeback.
// Rev     : 1.0
// ============================================================================
module tb_z16_writeback;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ex_valid;
    logic        o_ex_ready;
    logic        i_ex_is_load;
    logic [3:0]  i_ex_rd_addr;
    logic [15:0] i_ex_data;
    logic        i_ld_valid;
    logic [15:0] i_ld_data;
    logic [3:0]  o_rd_addr;
    logic        o_rd_wen;
    logic [15:0] o_rd_data;
    logic [15:0] o_busy;
    logic        o_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 i_clk = ~i_clk;

    z16_writeback #(
        .LOAD_DEPTH (2)
    ) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ex_valid   (i_ex_valid),
        .o_ex_ready   (o_ex_ready),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_rd_addr (i_ex_rd_addr),
        .i_ex_data    (i_ex_data),
        .i_ld_valid   (i_ld_valid),
        .i_ld_data    (i_ld_data),
        .o_rd_addr    (o_rd_addr),
        .o_rd_wen     (o_rd_wen),
        .o_rd_data    (o_rd_data),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_ex_valid   = 1'b0;
        i_ex_is_load = 1'b0;
        i_ex_rd_addr = 4'h0;
        i_ex_data    = 16'h0;
        i_ld_valid   = 1'b0;
        i_ld_data    = 16'h0;
    endtask

    task automatic ex(input logic is_load, input logic [3:0] rd, input logic [15:0] data);
        i_ex_valid   = 1'b1;
        i_ex_is_load = is_load;
        i_ex_rd_addr = rd;
        i_ex_data    = data;
    endtask

    task automatic ld(input logic [15:0] data);
        i_ld_valid = 1'b1;
        i_ld_data  = data;
    endtask

    task automatic chk_wr(input string tag, input logic wen, input logic [3:0] addr,
                          input logic [15:0] data);
        chk({tag, "_wen"}, 32'(o_rd_wen), 32'(wen));
        if (wen) begin
            chk({tag, "_addr"}, 32'(o_rd_addr), 32'(addr));
            chk({tag, "_data"}, 32'(o_rd_data), 32'(data));
        end
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        chk("rst_wen",  32'(o_rd_wen),  32'h0);
        chk("rst_addr", 32'(o_rd_addr), 32'h0);
        chk("rst_data", 32'(o_rd_data), 32'h0);
        chk("rst_busy", 32'(o_busy),    32'h0);
        chk("rst_err",  32'(o_err),     32'h0);
        chk("rst_ready_idle", 32'(o_ex_ready), 32'h1);
        i_ld_valid = 1'b1;
        #1;
        chk("rst_ready_ldv", 32'(o_ex_ready), 32'h0);
        i_ld_valid = 1'b0;
        #1;

        // ALU op rd=3
        ex(1'b0, 4'd3, 16'hBEEF);
        #1;
        chk("alu_ready", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        chk_wr("alu_wr", 1'b1, 4'd3, 16'hBEEF);
        chk("alu_busy", 32'(o_busy), 32'h0);
        tick();
        chk("alu_wen_once", 32'(o_rd_wen), 32'h0);

        // Load rd=5, response three cycles later
        ex(1'b1, 4'd5, 16'h0);
        #1;
        chk("ld5_ready", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        chk("ld5_busy_set", 32'(o_busy), 32'h0020);
        chk("ld5_no_wen", 32'(o_rd_wen), 32'h0);
        tick();
        tick();
        chk("ld5_busy_hold", 32'(o_busy), 32'h0020);
        ld(16'h1234);
        tick();
        idle();
        chk_wr("ld5_wr", 1'b1, 4'd5, 16'h1234);
        chk("ld5_busy_clr", 32'(o_busy), 32'h0);
        tick();
        chk("ld5_wen_once", 32'(o_rd_wen), 32'h0);

        // ALU rd=2 collides with response for r7
        ex(1'b1, 4'd7, 16'h0);
        tick();
        idle();
        ex(1'b0, 4'd2, 16'h0022);
        ld(16'h7777);
        #1;
        chk("col_ready_lo", 32'(o_ex_ready), 32'h0);
        tick();
        i_ld_valid = 1'b0;
        #1;
        chk_wr("col_wr7", 1'b1, 4'd7, 16'h7777);
        chk("col_ready_hi", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        chk_wr("col_wr2", 1'b1, 4'd2, 16'h0022);
        chk("col_busy", 32'(o_busy), 32'h0);
        tick();

        // FIFO full: loads r1, r2 then r4 stalls until first response
        ex(1'b1, 4'd1, 16'h0);
        tick();
        ex(1'b1, 4'd2, 16'h0);
        tick();
        ex(1'b1, 4'd4, 16'h0);
        #1;
        chk("full_busy", 32'(o_busy), 32'h0006);
        chk("full_ready_lo", 32'(o_ex_ready), 32'h0);
        ld(16'h1111);
        #1;
        chk("full_ready_pop", 32'(o_ex_ready), 32'h0);
        tick();
        i_ld_valid = 1'b0;
        #1;
        chk_wr("full_wr1", 1'b1, 4'd1, 16'h1111);
        chk("full_ready_hi", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        ld(16'h2222);
        tick();
        idle();
        chk_wr("full_wr2", 1'b1, 4'd2, 16'h2222);
        chk("full_busy4", 32'(o_busy), 32'h0010);
        ld(16'h4444);
        tick();
        idle();
        chk_wr("full_wr4", 1'b1, 4'd4, 16'h4444);
        chk("full_busy_end", 32'(o_busy), 32'h0);
        tick();

        // r0 ops and WAW stall on r1
        ex(1'b0, 4'd0, 16'h5555);
        #1;
        chk("r0_alu_ready", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        chk("r0_alu_wen", 32'(o_rd_wen), 32'h0);
        ex(1'b1, 4'd0, 16'h0);
        tick();
        idle();
        chk("r0_ld_busy", 32'(o_busy), 32'h0);
        ex(1'b1, 4'd1, 16'h0);
        #1;
        chk("waw_ld1_ready", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        chk("waw_busy1", 32'(o_busy), 32'h0002);
        ld(16'hAAAA);
        tick();
        idle();
        chk("r0_resp_wen", 32'(o_rd_wen), 32'h0);
        chk("r0_resp_busy", 32'(o_busy), 32'h0002);
        chk("r0_resp_err", 32'(o_err), 32'h0);
        ex(1'b0, 4'd1, 16'h0101);
        #1;
        chk("waw_ready_lo", 32'(o_ex_ready), 32'h0);
        tick();
        chk("waw_still_lo", 32'(o_ex_ready), 32'h0);
        chk("waw_no_wen", 32'(o_rd_wen), 32'h0);
        ld(16'h1010);
        tick();
        i_ld_valid = 1'b0;
        #1;
        chk_wr("waw_ld_wr", 1'b1, 4'd1, 16'h1010);
        chk("waw_busy_clr", 32'(o_busy), 32'h0);
        chk("waw_ready_hi", 32'(o_ex_ready), 32'h1);
        tick();
        idle();
        chk_wr("waw_alu_wr", 1'b1, 4'd1, 16'h0101);
        tick();

        // Spurious response, sticky error, reset mid-load
        ld(16'h9999);
        tick();
        idle();
        chk("err_set", 32'(o_err), 32'h1);
        chk("err_no_wen", 32'(o_rd_wen), 32'h0);
        tick();
        tick();
        chk("err_sticky", 32'(o_err), 32'h1);
        ex(1'b1, 4'd6, 16'h0);
        tick();
        idle();
        chk("mid_busy6", 32'(o_busy), 32'h0040);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        chk("mid_rst_err", 32'(o_err), 32'h0);
        chk("mid_rst_wen", 32'(o_rd_wen), 32'h0);
        ld(16'h6666);
        tick();
        idle();
        chk("late_err", 32'(o_err), 32'h1);
        chk("late_no_wen", 32'(o_rd_wen), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_z16_writeback
`default_nettype wire
